// File: rtl/hwpe_stream_addressgen_sched.sv
// Job scheduler for a shared address generator.
// Round-robin arbitration over NB_REQ requesters: grant, clear/presample, run until the
// address generator reports done, then pulse the requester's done strobe.
module hwpe_stream_addressgen_sched #(
  parameter int unsigned NB_REQ = 2,
  parameter int unsigned ID_W   = (NB_REQ > 1) ? $clog2(NB_REQ) : 1,
  parameter type ctrl_addressgen_v3_t = logic [31:0]
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                enable_i,
  input  logic [NB_REQ-1:0]   req_valid_i,
  output logic [NB_REQ-1:0]   req_ready_o,
  input  ctrl_addressgen_v3_t req_ctrl_i [NB_REQ],
  output logic [NB_REQ-1:0]   req_done_o,
  output ctrl_addressgen_v3_t ag_ctrl_o,
  output logic                ag_clear_o,
  output logic                ag_presample_o,
  output logic                ag_enable_o,
  input  logic                ag_done_i,
  output logic                busy_o,
  output logic [ID_W-1:0]     cur_id_o
);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  localparam logic [ID_W-1:0] LastInit = ID_W'(NB_REQ - 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [ID_W-1:0]     cur_q, cur_d;
  ctrl_addressgen_v3_t ctrl_q, ctrl_d;
  logic [NB_REQ-1:0]   done_q, done_d;

  logic                grant_found;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     cand;

  // Round-robin search: upward from last_q+1, wrapping; depends on valid only, never on ctrl.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= NB_REQ; i++) begin
      cand = ID_W'((32'(last_q) + i) % NB_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // FSM next state and Moore/Mealy outputs; everything is quiet while reset is asserted.
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    cur_d          = cur_q;
    ctrl_d         = ctrl_q;
    done_d         = '0;
    req_ready_o    = '0;
    ag_clear_o     = 1'b0;
    ag_presample_o = 1'b0;
    ag_enable_o    = 1'b0;
    if (!rst_ni) begin
      state_d = StIdle;
    end else if (clear_i) begin
      // Abort wins over stall; last_q is kept so fairness survives the abort.
      state_d    = StIdle;
      ag_clear_o = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable_i && grant_found) begin
            req_ready_o[grant_id] = 1'b1;
            ctrl_d                = req_ctrl_i[grant_id];
            cur_d                 = grant_id;
            last_d                = grant_id;
            state_d               = StClear;
          end
        end
        StClear: begin
          if (enable_i) begin
            ag_clear_o     = 1'b1;
            ag_presample_o = 1'b1;
            state_d        = StRun;
          end
        end
        StRun: begin
          ag_enable_o = enable_i;
          if (enable_i && ag_done_i) state_d = StDone;
        end
        StDone: begin
          if (enable_i) begin
            done_d[cur_q] = 1'b1;
            state_d       = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers; done strobe is registered so it leaves one cycle after DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      last_q  <= LastInit;
      cur_q   <= '0;
      ctrl_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      ctrl_q  <= ctrl_d;
      done_q  <= done_d;
    end
  end

  assign req_done_o = done_q & {NB_REQ{~clear_i}};
  assign ag_ctrl_o  = ctrl_q;
  assign busy_o     = (state_q != StIdle);
  assign cur_id_o   = cur_q;

endmodule

// File: tb/tb_hwpe_stream_addressgen_sched.sv
// Directed bench with a ready/done scoreboard for hwpe_stream_addressgen_sched.
module tb_hwpe_stream_addressgen_sched;

  localparam int unsigned NbReq = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             clear_i = 1'b0;
  logic             enable_i = 1'b0;
  logic [NbReq-1:0] req_valid_i = '0;
  logic [NbReq-1:0] req_ready_o;
  logic [31:0]      req_ctrl [NbReq];
  logic [NbReq-1:0] req_done_o;
  logic [31:0]      ag_ctrl_o;
  logic             ag_clear_o, ag_presample_o, ag_enable_o;
  logic             ag_done_i = 1'b0;
  logic             busy_o;
  logic [0:0]       cur_id_o;

  hwpe_stream_addressgen_sched #(.NB_REQ(NbReq)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .enable_i      (enable_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_ctrl_i    (req_ctrl),
    .req_done_o    (req_done_o),
    .ag_ctrl_o     (ag_ctrl_o),
    .ag_clear_o    (ag_clear_o),
    .ag_presample_o(ag_presample_o),
    .ag_enable_o   (ag_enable_o),
    .ag_done_i     (ag_done_i),
    .busy_o        (busy_o),
    .cur_id_o      (cur_id_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int unsigned id;
    int unsigned cyc;
  } ev_t;

  ev_t rdy_q[$];
  ev_t done_q[$];
  ev_t mon_e;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_rdy(input int unsigned id, input int unsigned c);
    rdy_q.push_back('{id: id, cyc: c});
  endtask

  task automatic push_done(input int unsigned id, input int unsigned c);
    done_q.push_back('{id: id, cyc: c});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: every ready/done strobe the DUT shows must match the next expected event.
  always @(negedge clk_i) begin
    if (req_ready_o != '0) begin
      if (rdy_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got %b at cycle %0d, expected none", req_ready_o, cyc);
      end else begin
        mon_e = rdy_q.pop_front();
        chk("ready_onehot", 32'(req_ready_o), 32'(1) << mon_e.id);
        chk("ready_cycle", cyc, mon_e.cyc);
      end
    end
    if (req_done_o != '0) begin
      if (done_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got %b at cycle %0d, expected none", req_done_o, cyc);
      end else begin
        mon_e = done_q.pop_front();
        chk("done_onehot", 32'(req_done_o), 32'(1) << mon_e.id);
        chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  int unsigned c0;

  initial begin
    req_ctrl[0] = 32'h55;
    req_ctrl[1] = 32'h0;
    enable_i    = 1'b1;
    req_valid_i = 2'b01;
    // Reset state, with a valid request pending.
    #12;
    chk("rst_ready", 32'(req_ready_o), 32'h0);
    chk("rst_done", 32'(req_done_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_cur_id", 32'(cur_id_o), 32'h0);
    chk("rst_ag_ctrl", ag_ctrl_o, 32'h0);
    chk("rst_ag_clear", 32'(ag_clear_o), 32'h0);
    chk("rst_presample", 32'(ag_presample_o), 32'h0);
    chk("rst_ag_enable", 32'(ag_enable_o), 32'h0);
    req_valid_i = '0;
    tick();
    rst_ni = 1'b1;
    tick();
    tick();

    // Single job, tot_len=4, done sampled in the fourth RUN cycle.
    tick();
    c0 = cyc;
    req_ctrl[0] = 32'd4;
    req_valid_i = 2'b01;
    push_rdy(0, c0);
    push_done(0, c0 + 7);
    tick();
    req_valid_i = '0;
    #1;
    chk("job_clear", 32'(ag_clear_o), 32'h1);
    chk("job_presample", 32'(ag_presample_o), 32'h1);
    chk("job_ag_ctrl", ag_ctrl_o, 32'd4);
    chk("job_cur_id", 32'(cur_id_o), 32'h0);
    chk("job_busy", 32'(busy_o), 32'h1);
    chk("job_enable_in_clear", 32'(ag_enable_o), 32'h0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      if (k == 5) ag_done_i = 1'b1;
      #1;
      chk("job_run_enable", 32'(ag_enable_o), 32'h1);
    end
    tick();
    ag_done_i = 1'b0;
    #1;
    chk("job_done_enable", 32'(ag_enable_o), 32'h0);
    chk("job_done_busy", 32'(busy_o), 32'h1);
    tick();
    #1;
    chk("job_idle_busy", 32'(busy_o), 32'h0);
    tick();

    // Zero-length job on requester 1, immediate ag_done_i.
    tick();
    c0 = cyc;
    req_ctrl[1] = 32'h0;
    req_valid_i = 2'b10;
    push_rdy(1, c0);
    push_done(1, c0 + 4);
    tick();
    req_valid_i = '0;
    #1;
    chk("zl_cur_id", 32'(cur_id_o), 32'h1);
    tick();
    ag_done_i = 1'b1;
    #1;
    chk("zl_run_enable", 32'(ag_enable_o), 32'h1);
    tick();
    ag_done_i = 1'b0;
    #1;
    chk("zl_done_enable", 32'(ag_enable_o), 32'h0);
    tick();
    #1;
    chk("zl_idle_busy", 32'(busy_o), 32'h0);
    tick();

    // Fairness: both requesters continuously valid, done always high.
    tick();
    c0 = cyc;
    req_valid_i = 2'b11;
    ag_done_i   = 1'b1;
    push_rdy(0, c0);
    push_rdy(1, c0 + 4);
    push_rdy(0, c0 + 8);
    push_rdy(1, c0 + 12);
    push_done(0, c0 + 4);
    push_done(1, c0 + 8);
    push_done(0, c0 + 12);
    push_done(1, c0 + 16);
    for (int k = 1; k <= 13; k++) tick();
    req_valid_i = '0;
    #1;
    chk("fair_cur_id", 32'(cur_id_o), 32'h1);
    chk("fair_busy", 32'(busy_o), 32'h1);
    for (int k = 14; k <= 17; k++) tick();
    ag_done_i = 1'b0;
    tick();

    // Stall: enable low for 3 RUN cycles with done pending.
    tick();
    c0 = cyc;
    req_ctrl[0] = 32'd7;
    req_valid_i = 2'b01;
    push_rdy(0, c0);
    push_done(0, c0 + 7);
    tick();
    req_valid_i = '0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      ag_done_i = 1'b1;
      enable_i  = 1'b0;
      #1;
      chk("stall_enable", 32'(ag_enable_o), 32'h0);
      chk("stall_busy", 32'(busy_o), 32'h1);
    end
    tick();
    enable_i = 1'b1;
    #1;
    chk("stall_resume_run", 32'(ag_enable_o), 32'h1);
    tick();
    ag_done_i = 1'b0;
    #1;
    chk("stall_done_enable", 32'(ag_enable_o), 32'h0);
    tick();
    #1;
    chk("stall_idle_busy", 32'(busy_o), 32'h0);
    tick();

    // Abort in RUN, then the other requester wins.
    tick();
    c0 = cyc;
    req_valid_i = 2'b11;
    push_rdy(1, c0);
    tick();
    req_valid_i = 2'b01;
    #1;
    chk("abort_cur_id", 32'(cur_id_o), 32'h1);
    tick();
    clear_i = 1'b1;
    #1;
    chk("abort_ag_clear", 32'(ag_clear_o), 32'h1);
    chk("abort_busy_run", 32'(busy_o), 32'h1);
    tick();
    clear_i = 1'b0;
    req_valid_i = 2'b11;
    push_rdy(0, c0 + 3);
    push_done(0, c0 + 7);
    #1;
    chk("abort_idle", 32'(busy_o), 32'h0);
    tick();
    req_valid_i = '0;
    #1;
    chk("abort_next_cur_id", 32'(cur_id_o), 32'h0);
    chk("abort_next_clear", 32'(ag_clear_o), 32'h1);
    tick();
    ag_done_i = 1'b1;
    tick();
    ag_done_i = 1'b0;
    tick();
    tick();

    // clear_i in IDLE blocks a pending grant.
    tick();
    req_valid_i = 2'b01;
    clear_i     = 1'b1;
    #1;
    chk("idle_clear_ready", 32'(req_ready_o), 32'h0);
    chk("idle_clear_ag_clear", 32'(ag_clear_o), 32'h1);
    tick();
    clear_i     = 1'b0;
    req_valid_i = '0;
    #1;
    chk("idle_clear_busy", 32'(busy_o), 32'h0);
    tick();

    // Async reset in CLEAR, then requester 0 goes first.
    tick();
    c0 = cyc;
    req_valid_i = 2'b10;
    push_rdy(1, c0);
    tick();
    req_valid_i = '0;
    #1;
    chk("ar_clear_before", 32'(ag_clear_o), 32'h1);
    req_valid_i = 2'b11;
    rst_ni      = 1'b0;
    #1;
    chk("ar_ag_clear", 32'(ag_clear_o), 32'h0);
    chk("ar_presample", 32'(ag_presample_o), 32'h0);
    chk("ar_busy", 32'(busy_o), 32'h0);
    chk("ar_cur_id", 32'(cur_id_o), 32'h0);
    chk("ar_ag_ctrl", ag_ctrl_o, 32'h0);
    chk("ar_ready", 32'(req_ready_o), 32'h0);
    tick();
    tick();
    rst_ni = 1'b1;
    push_rdy(0, cyc);
    push_done(0, cyc + 4);
    tick();
    req_valid_i = '0;
    #1;
    chk("ar_regrant_cur_id", 32'(cur_id_o), 32'h0);
    tick();
    ag_done_i = 1'b1;
    tick();
    ag_done_i = 1'b0;
    tick();
    tick();
    tick();

    chk("ready_events_left", 32'(rdy_q.size()), 32'h0);
    chk("done_events_left", 32'(done_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_addressgen_sched.md
HWPE_STREAM_ADDRESSGEN_SCHED -- requirements
Module: hwpe_stream_addressgen_sched

Interface
REQ-001 Parameter NB_REQ, default 2, SHALL set the number of job requesters (legal range 1..16).
REQ-002 Parameter ID_W, default $clog2(NB_REQ) with a minimum of 1, SHALL set the width of the requester index.
REQ-003 clk_i  in  1  SHALL be the clock.
REQ-004 rst_ni  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 clear_i  in  1  SHALL be a synchronous abort: return to IDLE and clear the address generator.
REQ-006 enable_i  in  1  SHALL be a global stall; while low, all state holds.
REQ-007 req_valid_i  in  NB_REQ  SHALL carry one job-request valid per requester.
REQ-008 req_ready_o  out  NB_REQ  SHALL carry the job-accept strobe, one-hot, one cycle long.
REQ-009 req_ctrl_i  in  NB_REQ x ctrl_addressgen_v3_t  SHALL carry the per-requester job configuration.
REQ-010 req_done_o  out  NB_REQ  SHALL carry the job-completion pulse, one-hot, one cycle long.
REQ-011 ag_ctrl_o  out  ctrl_addressgen_v3_t  SHALL drive the latched configuration to the address generator.
REQ-012 ag_clear_o  out  1  SHALL drive the address-generator clear.
REQ-013 ag_presample_o  out  1  SHALL drive the address-generator presample.
REQ-014 ag_enable_o  out  1  SHALL drive the address-generator enable.
REQ-015 ag_done_i  in  1  SHALL receive the address-generator done flag.
REQ-016 busy_o  out  1  SHALL be high in every state except IDLE.
REQ-017 cur_id_o  out  ID_W  SHALL give the index of the granted or running requester.

Function
REQ-018 The FSM SHALL have the states IDLE, CLEAR, RUN and DONE, encoded in registers.
REQ-019 In IDLE, when any req_valid_i bit is set and enable_i=1, the block SHALL do all of the following in the same cycle:
  - select the winner by round-robin, searching upward and wrapping from index last_q+1;
  - assert req_ready_o[winner];
  - latch req_ctrl_i[winner] into ag_ctrl_o;
  - load cur_id_o and last_q with the winner;
  - move to CLEAR.
REQ-020 Requesters SHALL hold valid and ctrl stable until ready; ready SHALL NOT depend combinationally on ctrl.
REQ-021 In CLEAR, ag_clear_o and ag_presample_o SHALL both be 1 for exactly one cycle, and the next state SHALL be RUN.
REQ-022 In RUN, ag_enable_o SHALL equal enable_i; the block SHALL sample ag_done_i only when enable_i=1.
REQ-023 In RUN, ag_done_i=1 with enable_i=1 SHALL cause a move to DONE; ag_enable_o SHALL be 0 in DONE.
REQ-024 In DONE, req_done_o[cur_id_o] SHALL pulse for one cycle, and the next state SHALL be IDLE.
REQ-025 The minimum job turnaround SHALL be 4 cycles (IDLE grant, CLEAR, RUN ≥1 cycle, DONE), so back-to-back grants are ≥4 cycles apart.
REQ-026 A job with tot_len=0 SHALL complete normally: the first sampled ag_done_i ends RUN.
REQ-027 ag_ctrl_o SHALL remain constant from grant until the next grant; the value in IDLE is don't-care but SHALL hold the last job.
REQ-028 clear_i=1 in any state SHALL:
  - force IDLE on the next edge;
  - assert ag_clear_o in that cycle;
  - suppress req_ready_o and req_done_o;
  - keep last_q unchanged.
  clear_i SHALL take priority over enable_i=0.
REQ-029 A request withdrawn before grant SHALL be legal; a grant SHALL occur only on a valid bit sampled in IDLE.
REQ-030 With NB_REQ=1, the arbiter SHALL degenerate to always granting index 0.
REQ-031 A requester whose valid is asserted in the DONE cycle of its own job SHALL be re-granted only if no other valid is set (round-robin fairness).
REQ-032 At most one req_ready_o bit and at most one req_done_o bit SHALL be high in any cycle.

Reset
REQ-033 Under rst_ni=0, the block SHALL hold:
  - state = IDLE;
  - last_q = NB_REQ-1, so requester 0 wins first;
  - cur_id_o = 0, busy_o = 0, ag_ctrl_o = '0;
  - all of req_ready_o, req_done_o, ag_clear_o, ag_presample_o, ag_enable_o = 0.
REQ-034 Reset asserted mid-job SHALL abort the job without a req_done_o pulse, and SHALL NOT be followed by any ag_clear_o pulse until the next grant.

Verification
REQ-035 Single job: NB_REQ=2, req 0 valid, tot_len=4, ag_done_i driven 4 cycles into RUN -> ready[0] at cycle 0, clear+presample at cycle 1, enable at cycles 2-5, done[0] at cycle 7.
REQ-036 Fairness: both requesters continuously valid after reset -> grant order 0,1,0,1; no grant overlaps a busy period.
REQ-037 Stall: enable_i=0 for 3 cycles during RUN with ag_done_i=1 -> no transition and ag_enable_o=0; DONE is reached only on the first cycle with enable_i=1.
REQ-038 Abort: clear_i pulsed in RUN -> IDLE next cycle; ag_clear_o=1 during the clear_i cycle; no done pulse; the next grant goes to the other requester.
REQ-039 Zero length: tot_len=0 with an immediate ag_done_i -> done pulse 4 cycles after ready.
REQ-040 Async reset asserted in CLEAR -> all outputs 0 immediately; after release, requester 0 is granted first.
